image_parallel_processing_mutex_client: RTL

- Per-CPU hardware helper that sits directly upstream of the Avalon hardware mutex slave. It turns simple lock/unlock commands into the mutex's write-then-verify bus protocol.
- The mutex register is 32 bits: [31:16] owner, [15:0] value; value==0 means free.
- On lock: writes {OWNER_ID, LOCK_VALUE} to address 0, reads it back to confirm ownership, and retries with backoff on contention.
- On unlock: writes {OWNER_ID, 16'h0}.
- Lets a processing core acquire a shared image buffer without software spin loops.

---
 rtl/image_parallel_processing_mutex_client_if.sv | 29 ++
 rtl/image_parallel_processing_mutex_client.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/image_parallel_processing_mutex_client_if.sv
// rtl/image_parallel_processing_mutex_client_if.sv - command/response and mutex bus bundle for the mutex client
// master is the client's view (drives the mutex bus); slave is the requester/fabric view.
interface image_parallel_processing_mutex_client_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic        locked;
  logic        m_address;
  logic        m_chipselect;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, m_readdata, m_waitrequest,
    output cmd_ready, rsp_valid, rsp_status, locked,
           m_address, m_chipselect, m_write, m_read, m_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, m_readdata, m_waitrequest,
    input  cmd_ready, rsp_valid, rsp_status, locked,
           m_address, m_chipselect, m_write, m_read, m_writedata
  );
endinterface

// File: rtl/image_parallel_processing_mutex_client.sv
// rtl/image_parallel_processing_mutex_client.sv - lock/unlock front end for the Avalon hardware mutex
// Optional MUTEX_CLIENT_LFSR_BACKOFF_EN adds a pseudo-random term to the retry backoff.
module image_parallel_processing_mutex_client #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int          BACKOFF_CYCLES = 8,
  parameter int          MAX_RETRIES    = 0
) (
  input logic clk,
  input logic reset_n,
  image_parallel_processing_mutex_client_if.master mif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK_WR,
    S_LOCK_RD,
    S_BACKOFF,
    S_UNLOCK_WR,
    S_RESP
  } state_t;

  localparam logic [31:0] LOCK_WORD    = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] UNLOCK_WORD  = {OWNER_ID, 16'h0000};
  localparam logic [15:0] BACKOFF_BASE = 16'(BACKOFF_CYCLES);
  localparam logic [15:0] RETRY_LIMIT  = 16'(MAX_RETRIES);
  localparam logic [1:0]  ST_OK        = 2'b00;
  localparam logic [1:0]  ST_TIMEOUT   = 2'b01;
  localparam logic [1:0]  ST_NOT_OWNER = 2'b10;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        locked_q, locked_d;
  logic        m_cs_q, m_cs_d;
  logic        m_wr_q, m_wr_d;
  logic        m_rd_q, m_rd_d;
  logic [31:0] m_wd_q, m_wd_d;
  logic [15:0] attempt_q, attempt_d;
  logic [15:0] backoff_q, backoff_d;
  logic [15:0] attempt_inc;
  logic [15:0] backoff_load;
  logic        bus_done;

`ifdef MUTEX_CLIENT_LFSR_BACKOFF_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign backoff_load = BACKOFF_BASE + {12'h000, lfsr_q[3:0]};
`else
  assign backoff_load = BACKOFF_BASE;
`endif

  assign bus_done    = ~mif.m_waitrequest;
  assign attempt_inc = (attempt_q == 16'hFFFF) ? attempt_q : attempt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    locked_d     = locked_q;
    m_cs_d       = m_cs_q;
    m_wr_d       = m_wr_q;
    m_rd_d       = m_rd_q;
    m_wd_d       = m_wd_q;
    attempt_d    = attempt_q;
    backoff_d    = backoff_q;
`ifdef MUTEX_CLIENT_LFSR_BACKOFF_EN
    lfsr_d       = lfsr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (mif.cmd_valid && cmd_ready_q) begin
          if (!mif.cmd_op) begin
            if (locked_q) begin
              state_d      = S_RESP;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_OK;
            end else begin
              state_d   = S_LOCK_WR;
              attempt_d = 16'd0;
              m_cs_d    = 1'b1;
              m_wr_d    = 1'b1;
              m_wd_d    = LOCK_WORD;
            end
          end else begin
            if (!locked_q) begin
              state_d      = S_RESP;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_NOT_OWNER;
            end else begin
              state_d = S_UNLOCK_WR;
              m_cs_d  = 1'b1;
              m_wr_d  = 1'b1;
              m_wd_d  = UNLOCK_WORD;
            end
          end
        end
      end

      S_LOCK_WR: begin
        if (bus_done) begin
          state_d = S_LOCK_RD;
          m_wr_d  = 1'b0;
          m_rd_d  = 1'b1;
        end
      end

      S_LOCK_RD: begin
        if (bus_done) begin
          m_cs_d = 1'b0;
          m_rd_d = 1'b0;
          if (mif.m_readdata == LOCK_WORD) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            locked_d     = 1'b1;
          end else begin
            attempt_d = attempt_inc;
            if (MAX_RETRIES != 0 && attempt_inc == RETRY_LIMIT) begin
              state_d      = S_RESP;
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_TIMEOUT;
            end else begin
              state_d   = S_BACKOFF;
              backoff_d = backoff_load;
`ifdef MUTEX_CLIENT_LFSR_BACKOFF_EN
              lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            end
          end
        end
      end

      // The loaded count is the number of idle cycles spent here.
      S_BACKOFF: begin
        backoff_d = backoff_q - 16'd1;
        if (backoff_q <= 16'd1) begin
          backoff_d = 16'd0;
          state_d   = S_LOCK_WR;
          m_cs_d    = 1'b1;
          m_wr_d    = 1'b1;
          m_wd_d    = LOCK_WORD;
        end
      end

      S_UNLOCK_WR: begin
        if (bus_done) begin
          state_d      = S_RESP;
          m_cs_d       = 1'b0;
          m_wr_d       = 1'b0;
          locked_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        m_cs_d  = 1'b0;
        m_wr_d  = 1'b0;
        m_rd_d  = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      locked_q     <= 1'b0;
      m_cs_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_rd_q       <= 1'b0;
      m_wd_q       <= 32'h0;
      attempt_q    <= 16'h0;
      backoff_q    <= 16'h0;
`ifdef MUTEX_CLIENT_LFSR_BACKOFF_EN
      lfsr_q       <= OWNER_ID[7:0] | 8'h01;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      locked_q     <= locked_d;
      m_cs_q       <= m_cs_d;
      m_wr_q       <= m_wr_d;
      m_rd_q       <= m_rd_d;
      m_wd_q       <= m_wd_d;
      attempt_q    <= attempt_d;
      backoff_q    <= backoff_d;
`ifdef MUTEX_CLIENT_LFSR_BACKOFF_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign mif.cmd_ready    = cmd_ready_q;
  assign mif.rsp_valid    = rsp_valid_q;
  assign mif.rsp_status   = rsp_status_q;
  assign mif.locked       = locked_q;
  assign mif.m_address    = 1'b0;
  assign mif.m_chipselect = m_cs_q;
  assign mif.m_write      = m_wr_q;
  assign mif.m_read       = m_rd_q;
  assign mif.m_writedata  = m_wd_q;

endmodule
